// File: rtl/button_gesture_pkg.sv
// Shared types and helpers for the push-button gesture decoder.
package button_gesture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG
  } state_t;

  // Counter must hold the largest terminal count of any state.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gesture_timer.sv
// Clearable up-counter with enable; flags the cycle the count equals a runtime limit.
module gesture_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_resetn,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_resetn)  r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + W'(1);
  end

  assign o_tc = i_en && (r_cnt == i_limit);

endmodule

// File: rtl/button_gesture_decoder.sv
// Classifies debounced button activity into click / double click / long press / auto-repeat.
module button_gesture_decoder
  import button_gesture_pkg::*;
#(
  parameter int LONG_CYCLES   = 12_500_000,
  parameter int GAP_CYCLES    = 6_250_000,
  parameter int REPEAT_CYCLES = 2_500_000
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_pb_state,
  input  logic i_pb_down,
  input  logic i_pb_up,
  output logic o_click,
  output logic o_double_click,
  output logic o_long_press,
  output logic o_repeat,
  output logic o_long_hold
);

  localparam int            CW       = cnt_width(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] LONG_LIM = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LIM  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] REP_LIM  = CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic          REP_EN   = (REPEAT_CYCLES > 0);

  state_t        r_state, w_nxt;
  logic          w_clr, w_en, w_tc;
  logic [CW-1:0] w_limit;
  logic          w_click, w_dbl, w_long, w_rep;
  logic          w_release;

  // A dropped level also counts as release, in case the up pulse was missed.
  assign w_release = i_pb_up | ~i_pb_state;

  gesture_timer #(.W(CW)) u_timer (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_clr    (w_clr),
    .i_en     (w_en),
    .i_limit  (w_limit),
    .o_tc     (w_tc)
  );

  always_ff @(posedge i_clk) begin
    if (!i_resetn) r_state <= IDLE;
    else           r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_clr   = 1'b0;
    w_en    = 1'b0;
    w_limit = '0;
    w_click = 1'b0;
    w_dbl   = 1'b0;
    w_long  = 1'b0;
    w_rep   = 1'b0;
    case (r_state)
      IDLE: begin
        w_clr = 1'b1;
        if (i_pb_down) w_nxt = PRESS1;
      end
      PRESS1: begin
        w_en    = 1'b1;
        w_limit = LONG_LIM;
        if (w_release) begin
          w_nxt = WAIT2;
          w_clr = 1'b1;
        end else if (w_tc) begin
          w_nxt  = LONG;
          w_clr  = 1'b1;
          w_long = 1'b1;
        end
      end
      WAIT2: begin
        w_en    = 1'b1;
        w_limit = GAP_LIM;
        if (i_pb_down) begin
          w_nxt = PRESS2;
          w_clr = 1'b1;
        end else if (w_tc) begin
          w_nxt   = IDLE;
          w_clr   = 1'b1;
          w_click = 1'b1;
        end
      end
      PRESS2: begin
        w_clr = 1'b1;
        if (w_release) begin
          w_nxt = IDLE;
          w_dbl = 1'b1;
        end
      end
      LONG: begin
        w_en    = REP_EN;
        w_limit = REP_LIM;
        // Release beats a coincident repeat wrap: no pulse on the way out.
        if (w_release) begin
          w_nxt = IDLE;
          w_clr = 1'b1;
        end else if (w_tc) begin
          w_clr = 1'b1;
          w_rep = 1'b1;
        end
      end
      default: begin
        w_nxt = IDLE;
        w_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      o_click        <= 1'b0;
      o_double_click <= 1'b0;
      o_long_press   <= 1'b0;
      o_repeat       <= 1'b0;
      o_long_hold    <= 1'b0;
    end else begin
      o_click        <= w_click;
      o_double_click <= w_dbl;
      o_long_press   <= w_long;
      o_repeat       <= w_rep;
      o_long_hold    <= (w_nxt == LONG);
    end
  end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed bench: expected output vectors are queued per cycle as stimulus is driven.
module tb_button_gesture_decoder;

  localparam int LONG = 8;
  localparam int GAP  = 4;
  localparam int REP  = 3;

  // Vector bit order: {long_hold, repeat, long_press, double_click, click}
  localparam logic [4:0] B_CLICK = 5'b00001;
  localparam logic [4:0] B_DBL   = 5'b00010;
  localparam logic [4:0] B_LONG  = 5'b00100;
  localparam logic [4:0] B_REP   = 5'b01000;
  localparam logic [4:0] B_HOLD  = 5'b10000;

  logic clk, resetn, pb_state, pb_down, pb_up;
  logic click, double_click, long_press, rpt, long_hold;

  typedef struct {
    int         cyc;
    logic [4:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   checks;
  int   failures;
  bit   mon_en;

  button_gesture_decoder #(
    .LONG_CYCLES   (LONG),
    .GAP_CYCLES    (GAP),
    .REPEAT_CYCLES (REP)
  ) dut (
    .i_clk          (clk),
    .i_resetn       (resetn),
    .i_pb_state     (pb_state),
    .i_pb_down      (pb_down),
    .i_pb_up        (pb_up),
    .o_click        (click),
    .o_double_click (double_click),
    .o_long_press   (long_press),
    .o_repeat       (rpt),
    .o_long_hold    (long_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle: outputs must equal the queued vector for this cycle, else all zero.
  always @(negedge clk) begin
    logic [4:0] obs;
    logic [4:0] ev;
    if (mon_en) begin
      obs = {long_hold, rpt, long_press, double_click, click};
      ev  = '0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        assert (0) else begin
          failures++;
          $error("FAIL stale_expect cyc=%0d observed=none required=%b", q[0].cyc, q[0].v);
        end
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) ev = q.pop_front().v;
      checks++;
      assert (obs === ev) else begin
        failures++;
        $error("FAIL outputs cyc=%0d observed=%b required=%b", cyc, obs, ev);
      end
    end
  end

  task automatic expect_at(input int c, input logic [4:0] v);
    exp_t e;
    if (q.size() > 0 && q[$].cyc == c) begin
      q[$].v = q[$].v | v;
    end else begin
      e.cyc = c;
      e.v   = v;
      q.push_back(e);
    end
  endtask

  task automatic drive(input logic s, input logic d, input logic u);
    pb_state = s;
    pb_down  = d;
    pb_up    = u;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int t0;
    cyc      = 0;
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    resetn   = 1'b0;
    pb_state = 1'b0;
    pb_down  = 1'b0;
    pb_up    = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    idle(3);

    // Single click: down t0, up t0+3
    t0 = cyc;
    drive(1'b1, 1'b1, 1'b0);
    hold(2);
    drive(1'b0, 1'b0, 1'b1);
    expect_at(t0 + 8, B_CLICK);
    idle(8);

    // Double click: down t0, up t0+2, down t0+4, up t0+10
    t0 = cyc;
    drive(1'b1, 1'b1, 1'b0);
    hold(1);
    drive(1'b0, 1'b0, 1'b1);
    idle(1);
    drive(1'b1, 1'b1, 1'b0);
    hold(5);
    drive(1'b0, 1'b0, 1'b1);
    expect_at(t0 + 11, B_DBL);
    idle(8);

    // Long press with auto-repeat, release in t0+20
    t0 = cyc;
    for (int c = t0 + 9; c <= t0 + 20; c++) begin
      logic [4:0] v;
      v = B_HOLD;
      if (c == t0 + 9) v = v | B_LONG;
      if (c == t0 + 12 || c == t0 + 15 || c == t0 + 18) v = v | B_REP;
      expect_at(c, v);
    end
    drive(1'b1, 1'b1, 1'b0);
    hold(19);
    drive(1'b0, 1'b0, 1'b1);
    idle(6);

    // Release exactly at terminal count of the long timer: short press
    t0 = cyc;
    drive(1'b1, 1'b1, 1'b0);
    hold(7);
    drive(1'b0, 1'b0, 1'b1);
    expect_at(t0 + 13, B_CLICK);
    idle(8);

    // Second press exactly GAP cycles after release: double click
    t0 = cyc;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    idle(3);
    drive(1'b1, 1'b1, 1'b0);
    hold(1);
    drive(1'b0, 1'b0, 1'b1);
    expect_at(t0 + 8, B_DBL);
    idle(8);

    // Reset during WAIT2 discards the pending click
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    idle(1);
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    idle(8);
    t0 = cyc;
    drive(1'b1, 1'b1, 1'b0);
    hold(1);
    drive(1'b0, 1'b0, 1'b1);
    expect_at(t0 + 7, B_CLICK);
    idle(8);

    // Missed up pulse: level drop alone acts as release
    t0 = cyc;
    drive(1'b1, 1'b1, 1'b0);
    hold(2);
    drive(1'b0, 1'b0, 1'b0);
    expect_at(t0 + 8, B_CLICK);
    idle(8);

    // Button held through reset: nothing until a fresh press
    resetn = 1'b0;
    hold(2);
    resetn = 1'b1;
    hold(12);
    drive(1'b0, 1'b0, 1'b1);
    idle(8);

    // Simultaneous down/up while in PRESS1: release is honoured
    t0 = cyc;
    drive(1'b1, 1'b1, 1'b0);
    hold(1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    expect_at(t0 + 7, B_CLICK);
    idle(8);

    mon_en = 1'b0;
    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL queue_drained observed=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_gesture_decoder.md
# button_gesture_decoder

Consumes the clean, clock-synchronous event stream from the push-button debouncer (held level plus one-cycle down/up pulses) and classifies each interaction as a single click, double click or long press, with optional auto-repeat while held. Sits between the debouncer and the application logic (menu/mode selection, LED pattern stepping), so downstream blocks see one pulse per user gesture instead of raw edges.

## Interface
- LONG_CYCLES, default 12_500_000: press duration that qualifies as long press (0.5 s at 25 MHz); must be ≥ 2.
- GAP_CYCLES, default 6_250_000: maximum released time between presses for a double click; must be ≥ 2.
- REPEAT_CYCLES, default 2_500_000: auto-repeat period while long-held; 0 disables repeat.
- clk  in  1  system clock; all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- pb_state  in  1  debounced level, 1 while button held.
- pb_down  in  1  one-cycle pulse on press.
- pb_up  in  1  one-cycle pulse on release.
- click  out  1  one-cycle pulse: single short press confirmed.
- double_click  out  1  one-cycle pulse: second press released.
- long_press  out  1  one-cycle pulse: press held LONG_CYCLES.
- repeat  out  1  one-cycle pulse every REPEAT_CYCLES while long-held.
- long_hold  out  1  level, high while in long-hold.

## Operation
- All outputs registered; reset value 0 for every output; state IDLE, counter 0.
- "Release" below means pb_up = 1 or pb_state = 0 (covers a missed pulse).
- IDLE: pb_down → PRESS1, counter cleared. Everything else ignored (button held through reset generates nothing until a fresh press).
- PRESS1: counter increments. Release → WAIT2, counter cleared. Counter == LONG_CYCLES-1 with no release → LONG, pulse long_press, counter cleared. Release and terminal count in same cycle: release wins (short press).
- WAIT2: counter increments. pb_down → PRESS2. Counter == GAP_CYCLES-1 with no pb_down → IDLE, pulse click. Both in same cycle: pb_down wins (double click).
- PRESS2: no timing. Release → IDLE, pulse double_click (regardless of hold length).
- LONG: long_hold = 1. If REPEAT_CYCLES > 0, counter increments and wraps at REPEAT_CYCLES-1, pulsing repeat on each wrap. Release → IDLE, counter cleared, no pulse.
- pb_down and pb_up simultaneously (illegal from debouncer): only the event relevant to the current state is honoured.
- Counter width: $clog2(max(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES)+1); no overflow possible since every state clears at terminal count.
- At most one of click/double_click/long_press/repeat high in any cycle.

## Timing
- pb_down in cycle t0 → PRESS1 from t0+1; long_press and long_hold high in cycle t0+LONG_CYCLES+1.
- Release in cycle t1 from PRESS1 → click high in t1+GAP_CYCLES+1 if no pb_down through cycle t1+GAP_CYCLES.
- Release in cycle t2 from PRESS2 → double_click high in t2+1.
- repeat first high REPEAT_CYCLES cycles after long_press, then every REPEAT_CYCLES cycles.
- long_hold falls in the cycle after release.
- resetn low in any cycle → next cycle all outputs 0, state IDLE; mid-gesture events discarded.

## Structure
- Package button_gesture_pkg: state enum (IDLE, PRESS1, WAIT2, PRESS2, LONG) and counter-width function.
- One sub-module gesture_timer: clearable up-counter with enable and terminal-count compare against a runtime limit; FSM selects the limit per state.

## Test plan
Params LONG=8, GAP=4, REPEAT=3.
- pb_down at t0, pb_up at t0+3, nothing else → click high only at t0+3+5 = t0+8; no other pulses.
- down t0, up t0+2, down t0+4, up t0+10 → double_click high only at t0+11; no click, no long_press.
- down t0, held to t0+20 → long_press at t0+9, long_hold t0+9..t0+20, repeat at t0+12, t0+15, t0+18; long_hold 0 at t0+21.
- Boundary: down t0, up exactly t0+8 → no long_press, treated as short; second down exactly 4 cycles after up → double click, not click.
- resetn low during WAIT2 while pb_state = 0 → all outputs 0, no click emitted; subsequent down/up produces a normal click.
- Missed pulse: down t0, pb_state drops at t0+3 with no pb_up → click at t0+8 as if pb_up.
